avg_pool_accumulator: RTL and testbench

Streaming 2x2 average-pool responder serving the pool layer's feed interface. The pool layer pushes the four window samples one per enabled cycle; this block accumulates them, rounds the sum divided by the window size, and returns one signed result with a single-cycle valid pulse. It sits directly beneath the pool layer in the CNN core, and windows may be streamed back-to-back without a gap cycle.

---
 rtl/avg_pool_accumulator.sv | 114 +++++++++++
 tb/tb_avg_pool_accumulator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/avg_pool_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | avg_pool_accumulator: streaming WINDOW-sample rounded average (rev 1.0)  |
// +------------------------------------------------------------------------+
module avg_pool_accumulator #(
  parameter int DATA_W = 32,
  parameter int WINDOW = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(WINDOW)-1:0] win_cnt,
  output logic                      busy
);

  localparam int K     = $clog2(WINDOW);
  localparam int ACC_W = DATA_W + K;
  localparam logic [K-1:0]     LAST_IDX   = K'(WINDOW - 1);
  localparam logic [ACC_W-1:0] ROUND_HALF = ACC_W'(1) << (K - 1);

  typedef enum logic [0:0] {
    EMPTY   = 1'b0,
    FILLING = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [K-1:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic               sum_v_q, sum_v_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;

  logic [ACC_W-1:0]   acc_plus;
  logic [ACC_W-1:0]   rnd;
  logic               window_done;
  logic               unused_rnd_lsbs;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    sum_v_d     = 1'b0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    state_d     = state_q;

    acc_plus    = acc_q + {{K{in_data[DATA_W-1]}}, in_data};
    // Adding half then keeping the bits above K is the arithmetic shift
    // with round-half-up; the upper DATA_W bits are the result.
    rnd         = sum_q + ROUND_HALF;
    window_done = in_valid && (cnt_q == LAST_IDX);

    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else begin
      out_valid_d = sum_v_q;
      if (sum_v_q) begin
        out_data_d = rnd[ACC_W-1:K];
      end
      if (in_valid) begin
        if (window_done) begin
          sum_d   = acc_plus;
          sum_v_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          acc_d = acc_plus;
          cnt_d = cnt_q + K'(1);
        end
      end
    end

    case (state_q)
      EMPTY:   if (!clr && in_valid) state_d = FILLING;
      FILLING: if (clr || window_done) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      sum_v_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      sum_v_q     <= sum_v_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign unused_rnd_lsbs = ^rnd[K-1:0];

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign win_cnt   = cnt_q;
  assign busy      = (state_q == FILLING) || sum_v_q || out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_avg_pool_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_avg_pool_accumulator: scoreboard bench for avg_pool_accumulator       |
// +------------------------------------------------------------------------+
module tb_avg_pool_accumulator;

  localparam int DATA_W = 32;
  localparam int WINDOW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        win_cnt;
  logic              busy;

  avg_pool_accumulator #(.DATA_W(DATA_W), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .win_cnt(win_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t   sb[$];
  longint win[$];
  int     checks = 0;
  int     failures = 0;

  // Round-half-up average by exact floor division on integers.
  function automatic logic [DATA_W-1:0] ref_avg(input longint s);
    longint t;
    longint q;
    t = s + WINDOW / 2;
    q = t / WINDOW;
    if ((t % WINDOW != 0) && (t < 0)) q = q - 1;
    return q[DATA_W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; updates the reference model after the capture edge.
  task automatic send(input bit v, input logic [DATA_W-1:0] d, input bit c);
    int     cap;
    longint s;
    bit     exp_busy;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clr      = c;
    @(posedge clk);
    #1;
    cap = cyc;
    if (c) begin
      win.delete();
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].due == cap) sb.delete(i);
    end else if (v) begin
      win.push_back(longint'($signed(d)));
      if (win.size() == WINDOW) begin
        s = 0;
        foreach (win[i]) s += win[i];
        sb.push_back('{ref_avg(s), cap + 1});
        win.delete();
      end
    end
    exp_busy = (win.size() != 0);
    foreach (sb[i]) if (sb[i].due == cap || sb[i].due == cap + 1) exp_busy = 1'b1;
    check("win_cnt", 64'(win_cnt), 64'(win.size()));
    check("busy", 64'(busy), 64'(exp_busy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, '0, 1'b0);
  endtask

  task automatic win4(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
    send(1'b1, a, 1'b0);
    send(1'b1, b, 1'b0);
    send(1'b1, c, 1'b0);
    send(1'b1, d, 1'b0);
  endtask

  // Monitor: every out_valid pops one expected result; overdue entries are misses.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_result expected=%0h due=%0d now=%0d", sb[0].data, sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL spurious_out_valid actual=%0h required=no_result cycle=%0d", out_data, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_data !== e.data || cyc != e.due) begin
            failures++;
            $display("FAIL result actual=%0h@%0d required=%0h@%0d", out_data, cyc, e.data, e.due);
          end
        end
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] d;
    bit v;
    bit c;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_win_cnt", 64'(win_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    win4(32'd10, 32'd20, 32'd30, 32'd40);
    idle(3);
    win4(32'd1, 32'd1, 32'd1, 32'd3);
    win4(-32'sd1, -32'sd1, -32'sd1, -32'sd3);
    win4(-32'sd1, -32'sd2, -32'sd2, -32'sd2);
    win4(32'd0, 32'd0, 32'd0, 32'd1);
    win4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    win4(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
    win4(32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000);
    idle(3);
    for (int i = 1; i <= 8; i++) send(1'b1, DATA_W'(i), 1'b0);
    idle(3);

    send(1'b1, 32'd5, 1'b0);
    send(1'b1, 32'd5, 1'b0);
    idle(3);
    send(1'b1, 32'd5, 1'b0);
    send(1'b1, 32'd5, 1'b0);
    idle(3);

    send(1'b1, 32'd9, 1'b0);
    send(1'b1, 32'd9, 1'b0);
    send(1'b1, 32'd100, 1'b1);
    win4(32'd1, 32'd2, 32'd3, 32'd4);
    idle(3);

    // Completed window immediately followed by clr: its pending result is dropped.
    win4(32'd7, 32'd7, 32'd7, 32'd7);
    send(1'b0, '0, 1'b1);
    idle(3);

    // Asynchronous reset between edges after three samples.
    send(1'b1, 32'd3, 1'b0);
    send(1'b1, 32'd3, 1'b0);
    send(1'b1, 32'd3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_data", 64'(out_data), 64'd0);
    check("arst_win_cnt", 64'(win_cnt), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    win.delete();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    win4(32'd8, 32'd8, 32'd8, 32'd8);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       d = 32'h7FFFFFFF;
        1:       d = 32'h80000000;
        2:       d = DATA_W'($urandom_range(0, 20)) - 32'd10;
        default: d = $urandom;
      endcase
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 24) == 0);
      send(v, d, c);
    end
    idle(5);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
